// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display: segment
// patterns, special nibble codes, the registered output bundle and small helpers.
package seg_scan_display_pkg;

    // Segment order {a,b,c,d,e,f,g,dp}, active-high; dp is always 0 here.
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam int NUM_TUBES = 8;

    typedef logic [2:0] tube_idx_t;

    typedef struct packed {
        logic [7:0] digit1;
        logic [7:0] digit2;
        logic [7:0] tube_sel;
    } disp_out_t;

    function automatic logic [3:0] nibble_at(input logic [31:0] data, input tube_idx_t idx);
        return data[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] tube_onehot(input tube_idx_t idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/seg_scan_display_decode.sv
// Nibble to seven-segment pattern; codes B..F render blank.
// Latency: combinational. Backpressure: none.
// The decimal point is not handled here; the caller merges it.
module seg_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_BLANK[7:1];
        case (nibble)
            4'h0:      segs = SEG_0[7:1];
            4'h1:      segs = SEG_1[7:1];
            4'h2:      segs = SEG_2[7:1];
            4'h3:      segs = SEG_3[7:1];
            4'h4:      segs = SEG_4[7:1];
            4'h5:      segs = SEG_5[7:1];
            4'h6:      segs = SEG_6[7:1];
            4'h7:      segs = SEG_7[7:1];
            4'h8:      segs = SEG_8[7:1];
            4'h9:      segs = SEG_9[7:1];
            CODE_DASH: segs = SEG_DASH[7:1];
            default:   segs = SEG_BLANK[7:1];
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-tube scanned seven-segment driver with frame-synchronous data snapshot and blink.
// Latency: outputs registered, one cycle after the tube index changes.
// Backpressure: none; free-running scan, enable only gates the outputs.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] time_data,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    tube_idx_t     idx;
    logic          blink_phase;
    logic [31:0]   snapshot;
    logic          load_pending;

    logic          scan_wrap;
    logic          frame_end;
    logic [31:0]   disp_data;
    logic [3:0]    cur_nibble;
    logic [6:0]    seg7;
    logic [7:0]    seg_byte;
    disp_out_t     disp_nxt;
    disp_out_t     disp_q;

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign frame_end = scan_wrap && (idx == tube_idx_t'(NUM_TUBES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    // The frame-end load captures the value present on that very cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot     <= 32'hFFFF_FFFF;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (load_pending || frame_end) begin
                snapshot <= time_data;
            end
        end
    end

    // On the first cycle after reset the snapshot is still blank, so tube 0
    // reads the incoming data directly to show fresh digits immediately.
    assign disp_data  = load_pending ? time_data : snapshot;
    assign cur_nibble = nibble_at(disp_data, idx);

    seg_decode u_seg_decode (
        .nibble (cur_nibble),
        .segs   (seg7)
    );

    always_comb begin
        seg_byte = {seg7, dp_mask[idx]};
        if (blink_phase && blink_mask[idx]) begin
            seg_byte = SEG_BLANK;
        end
    end

    always_comb begin
        disp_nxt = '0;
        if (enable) begin
            disp_nxt.tube_sel = tube_onehot(idx);
            if (idx[2]) begin
                disp_nxt.digit1 = seg_byte;
            end else begin
                disp_nxt.digit2 = seg_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_nxt;
        end
    end

    assign digit1   = disp_q.digit1;
    assign digit2   = disp_q.digit2;
    assign tube_sel = disp_q.tube_sel;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised scoreboard bench for seg_scan_display: a driver predicts each
// registered output word from a frame/time model, a monitor checks after each edge.
module tb_seg_scan_display;

    localparam int SD = 4;
    localparam int BD = 64;
    localparam int FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] time_data = 32'hF0F0_F912;
    logic [7:0]  blink_mask = 8'h00;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  seg_tab[16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Model state: edges since reset release and the frame's captured data.
    int          m_cnt = 0;
    logic [31:0] m_snap = 32'hFFFF_FFFF;

    seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .time_data  (time_data),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .digit1     (digit1),
        .digit2     (digit2),
        .tube_sel   (tube_sel)
    );

    always #5 clk = ~clk;

    function automatic int m_idx();
        return (m_cnt / SD) % 8;
    endfunction

    // Predict the output word produced by the next rising edge, then wait for the falling edge.
    task automatic step();
        logic [23:0] e;
        logic [7:0]  b;
        int          k;
        int          ph;
        e = '0;
        if (rst) begin
            m_cnt = 0;
        end else begin
            if (m_cnt == 0) m_snap = time_data;
            k  = m_idx();
            ph = (m_cnt / BD) % 2;
            if (enable) begin
                b = seg_tab[(m_snap >> (4 * k)) & 32'hF] | {7'd0, dp_mask[k]};
                if (ph == 1 && blink_mask[k]) b = 8'h00;
                if (k >= 4) e[23:16] = b;
                else        e[15:8]  = b;
                e[7:0] = 8'(1 << k);
            end
            if (m_cnt % FRAME == FRAME - 1) m_snap = time_data;
            m_cnt++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_idx(input int k);
        for (int i = 0; i < 64 && m_idx() != k; i++) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({digit1, digit2, tube_sel} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset t=%0t got %h want 000000", $time, {digit1, digit2, tube_sel});
        end
        run(2);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [23:0] e;
        cyc++;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({digit1, digit2, tube_sel} !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got d1=%h d2=%h sel=%h want d1=%h d2=%h sel=%h",
                         cyc, digit1, digit2, tube_sel, e[23:16], e[15:8], e[7:0]);
            end
        end
    end

    initial begin
        @(negedge clk);
        run(2);
        rst = 1'b0;
        // Power-up scan with mixed digits.
        run(40);

        // Dash on tube 5 with and without its decimal point.
        time_data = 32'h00A0_0000;
        run(FRAME + 8);
        dp_mask = 8'h20;
        run(FRAME);
        dp_mask = 8'h00;

        // Mid-frame data change must wait for the next frame.
        time_data = 32'h0000_0000;
        run(FRAME + 4);
        run_until_idx(3);
        time_data = 32'h1111_1111;
        run(2 * FRAME);

        // Blinking on tubes 0 and 1.
        blink_mask = 8'h03;
        time_data  = 32'hFFFF_FF55;
        run(4 * BD);
        blink_mask = 8'h00;

        // Enable dropped and restored mid-scan.
        run_until_idx(2);
        step();
        enable = 1'b0;
        run(11);
        enable = 1'b1;
        run(FRAME);

        // Reset while tube 6 is selected.
        time_data = 32'h7654_3210;
        run_until_idx(6);
        step();
        time_data = 32'h9876_5432;
        pulse_reset();
        run(FRAME + 4);

        // Randomised soak: data, masks, enable and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)   time_data  = $urandom;
            if ($urandom_range(0, 40) == 0)  blink_mask = 8'($urandom);
            if ($urandom_range(0, 10) == 0)  dp_mask    = 8'($urandom);
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step();
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
